// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with sequential/jump/call/return/trap redirection
// and a small circular return-address stack with sticky overflow/underflow status.
module pc_unit_ras #(
  parameter int unsigned             WIDTH        = 32,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]        TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned             INSTR_BYTES  = 4,
  parameter int unsigned             RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] target_pc,
  input  logic             trap,
  input  logic             ras_flush,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);

  localparam int unsigned      PW         = $clog2(RAS_DEPTH);
  localparam int unsigned      CW         = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C    = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] STEP_C     = WIDTH'(INSTR_BYTES);

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_JUMP = 2'b01,
    SEL_CALL = 2'b10,
    SEL_RET  = 2'b11
  } sel_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];

  logic [CW-1:0]    eff_cnt_s;
  logic [PW-1:0]    eff_ptr_s;
  logic [PW-1:0]    pop_idx_s;
  logic             bad_align_s;
  logic             push_s;

  assign pc_plus     = pc_q + STEP_C;
  assign bad_align_s = |(target_pc & ALIGN_MASK);
  // A flush on the same edge makes a push/pop see an empty stack.
  assign eff_cnt_s   = ras_flush ? {CW{1'b0}} : cnt_q;
  assign eff_ptr_s   = ras_flush ? {PW{1'b0}} : ptr_q;
  assign pop_idx_s   = eff_ptr_s - PW'(1);

  // Next-state selection: trap, then flush, then the stall-gated sel modes.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    mis_d  = 1'b0;
    push_s = 1'b0;
    if (trap) begin
      pc_d = TRAP_VECTOR;
    end else begin
      cnt_d = eff_cnt_s;
      ptr_d = eff_ptr_s;
      if (pc_write) begin
        case (sel_e'(sel))
          SEL_SEQ: pc_d = pc_plus;
          SEL_JUMP: begin
            if (bad_align_s) begin
              pc_d  = pc_plus;
              mis_d = 1'b1;
            end else begin
              pc_d = target_pc;
            end
          end
          SEL_CALL: begin
            if (bad_align_s) begin
              pc_d  = pc_plus;
              mis_d = 1'b1;
            end else begin
              pc_d   = target_pc;
              push_s = 1'b1;
              ptr_d  = eff_ptr_s + PW'(1);
              if (eff_cnt_s == DEPTH_C) begin
                ovf_d = 1'b1;
              end else begin
                cnt_d = eff_cnt_s + CW'(1);
              end
            end
          end
          SEL_RET: begin
            if (eff_cnt_s != {CW{1'b0}}) begin
              pc_d  = stack_q[pop_idx_s];
              ptr_d = pop_idx_s;
              cnt_d = eff_cnt_s - CW'(1);
            end else begin
              unf_d = 1'b1;
              if (bad_align_s) begin
                pc_d  = pc_plus;
                mis_d = 1'b1;
              end else begin
                pc_d = target_pc;
              end
            end
          end
          default: pc_d = pc_q;
        endcase
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State registers and RAS storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= {CW{1'b0}};
      ptr_q <= {PW{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        stack_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
      if (push_s) begin
        stack_q[eff_ptr_s] <= pc_plus;
      end
    end
  end

  assign pc            = pc_q;
  assign ras_empty     = (cnt_q == {CW{1'b0}});
  assign ras_full      = (cnt_q == DEPTH_C);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misalign      = mis_q;

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised next-generation program counter for the fetch stage. It holds the current PC and advances it sequentially, or redirects it on jump, call, return or trap. A small circular return-address stack (RAS) supplies return targets. It adds a write-enable/stall, trap vectoring, alignment checking and overflow/underflow status.

Parameters:
WIDTH, 32, PC and address width in bits (>= 8)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
INSTR_BYTES, 4, sequential increment; power of two (1, 2, 4 or 8)
RAS_DEPTH, 4, RAS entries; power of two, >= 2

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
pc_write  in  1  1 = PC may update this cycle; 0 = stall
sel  in  2  next-PC mode: 00 seq, 01 jump, 10 call, 11 return
target_pc  in  WIDTH  jump/call target; fallback target for return on empty RAS
trap  in  1  force PC to TRAP_VECTOR; overrides stall and sel
ras_flush  in  1  empty the RAS
pc  out  WIDTH  current PC (registered)
pc_plus  out  WIDTH  pc + INSTR_BYTES (combinational from pc, mod 2^WIDTH)
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_overflow  out  1  sticky; set on a push while full
ras_underflow  out  1  sticky; set on a pop while empty
misalign  out  1  registered 1-cycle pulse on a rejected misaligned target

Behaviour:
- Reset while reset=0, regardless of clock: pc=RESET_VECTOR, RAS count=0, pointer=0, ras_overflow=ras_underflow=misalign=0. All outputs have these values one delta after reset asserts, including mid-operation.
- Updates occur on the rising clk edge. New pc is visible the cycle after the request (1-cycle latency).
- Priority: trap > ras_flush (RAS only) > pc_write/sel.
- trap=1: pc<=TRAP_VECTOR. RAS and sticky flags are unchanged, and sel is ignored. This applies even when pc_write=0.
- pc_write=0 and trap=0: pc holds, sel is ignored, and the RAS does not push or pop. ras_flush still applies.
- sel=00: pc<=pc+INSTR_BYTES. It wraps modulo 2^WIDTH, for example WIDTH=32: 32'hFFFF_FFFC -> 32'h0000_0000.
- sel=01: pc<=target_pc.
- sel=10: push pc_plus onto the RAS, and pc<=target_pc.
  - When full, the push overwrites the oldest entry (circular), count stays RAS_DEPTH, and ras_overflow is set.
- sel=11, RAS not empty: pop the top entry, pc<=popped value, count-1.
- sel=11, RAS empty: pc<=target_pc and ras_underflow is set.
- Alignment: for sel 01/10, if target_pc[log2(INSTR_BYTES)-1:0] != 0:
  - pc<=pc+INSTR_BYTES instead
  - no push occurs
  - misalign=1 for the next cycle only
  - With INSTR_BYTES=1 there is no check.
- Popped return addresses are not alignment-checked, since they are pushed aligned. A fallback target on empty return is checked as for sel 01.
- ras_flush=1: count<=0 and pointer<=0 this edge, with no effect on sticky flags.
  - Same edge as sel=10: flush first, then push, so the end count is 1.
  - Same edge as sel=11: the RAS is treated as empty. pc<=target_pc and ras_underflow is set.
- Sticky flags clear only on reset.
- ras_empty/ras_full are combinational from the registered count. They are never both 1.
- The RAS pointer and count arithmetic wraps modulo RAS_DEPTH with no out-of-range index.

Test Plan:
1. Reset and sequential advance: reset=0 for 2 cycles, then reset=1, pc_write=1, sel=00 for 3 edges -> pc 0x0, 0x4, 0x8, 0xC. Also assert reset=0 mid-run -> pc=0x0 immediately.
2. Stall and trap: at pc=0x8, set pc_write=0, sel=01, target=0x40 for 2 edges -> pc stays 0x8. Then trap=1 with pc_write=0 -> pc=0x100.
3. Call and return nesting: at pc=0x10, call 0x200, then call 0x300, then return twice -> pc 0x200, 0x300, 0x204, 0x14. ras_empty=1 at the end, with no sticky flag set.
4. RAS overflow: 5 calls from pc=0x0 to targets 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_full=1, ras_overflow=1. Then 4 returns give 0x404, 0x304, 0x204, 0x104. A 5th return with target 0x80 -> pc=0x80, ras_underflow=1.
5. Misalignment and wrap: at pc=0x20, jump to 0x42 -> pc=0x24 and misalign high for exactly 1 cycle. Then jump to 0xFFFF_FFFC and seq -> pc=0x0.
6. Flush interaction: push 2 entries, then on one edge apply ras_flush=1 with sel=10, target 0x600, from pc=0x50 -> pc=0x600 and count=1. Return -> pc=0x54, ras_empty=1.
